// File: rtl/router_pkg.sv
// Shared state encoding, header field layout and helpers for the router ingress slice.
package router_pkg;

  localparam int LEN_W        = 6;
  localparam int ADDR_W       = 2;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    PAYLOAD,
    PARITY_DRAIN,
    CHECK,
    DROP
  } state_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/router_hold_reg.sv
// Single-entry skid register between the ingress FSM and the FIFO write port.
// A load on the same edge as a drain simply reloads, so the stream keeps 1 byte/clk.
module router_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              load_first,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic              flush,
  output logic              valid,
  output logic              first,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic              first_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      first_reg <= load_first;
      data_reg  <= load_data;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign first = first_reg;
  assign data  = data_reg;

endmodule

// File: rtl/router_ingress_ctrl.sv
// Router ingress control: header decode, FIFO steering, source throttling, parity check.
// Build option: define ROUTER_LEN_CHECK_EN to also flag a payload-count mismatch in err.
module router_ingress_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [DATA_W-1:0]    dout,
  output logic                 parity_done,
  output logic                 err
);

  localparam int SEL_W = 2 ** ADDR_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] parity_reg, parity_next;
  logic [DATA_W-1:0] rx_parity_reg, rx_parity_next;
  logic              err_reg, err_next;
`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
`endif

  logic [SEL_W-1:0]  full_sel;
  logic [SEL_W-1:0]  empty_sel;
  logic [SEL_W-1:0]  flush_sel;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hold_valid;
  logic              hold_first;
  logic [DATA_W-1:0] hold_data;
  logic              hold_load;
  logic              hold_flush;
  logic              drain_ok;
  logic              accept;
  logic              abort;

  // Widen per-port vectors so the 2-bit address can index them without range gaps.
  assign full_sel  = SEL_W'(fifo_full);
  assign empty_sel = SEL_W'(fifo_empty);
  assign flush_sel = SEL_W'(soft_reset);
  assign hdr_addr  = data_in[HDR_ADDR_LSB +: ADDR_W];

  assign drain_ok = hold_valid & ~full_sel[addr_reg] & (state_reg != WAIT_EMPTY);
  assign busy     = (hold_valid & full_sel[addr_reg]) |
                    (state_reg inside {WAIT_EMPTY, PARITY_DRAIN, CHECK});
  assign accept   = ~busy & (pkt_valid | (state_reg == PAYLOAD));
  assign abort    = flush_sel[addr_reg] &
                    (state_reg inside {WAIT_EMPTY, PAYLOAD, PARITY_DRAIN, CHECK});

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wr
      assign write_enb[gi] = drain_ok & (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  assign dout      = hold_data;
  assign lfd_state = hold_first;
  assign err       = err_reg;

  router_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk       (clk),
    .resetn    (resetn),
    .load      (hold_load),
    .load_first(state_reg == IDLE),
    .load_data (data_in),
    .drain     (drain_ok),
    .flush     (hold_flush),
    .valid     (hold_valid),
    .first     (hold_first),
    .data      (hold_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      parity_reg    <= '0;
      rx_parity_reg <= '0;
      err_reg       <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
      len_reg       <= '0;
      cnt_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      parity_reg    <= parity_next;
      rx_parity_reg <= rx_parity_next;
      err_reg       <= err_next;
`ifdef ROUTER_LEN_CHECK_EN
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    parity_next    = parity_reg;
    rx_parity_next = rx_parity_reg;
    err_next       = err_reg;
`ifdef ROUTER_LEN_CHECK_EN
    len_next       = len_reg;
    cnt_next       = cnt_reg;
`endif
    hold_load      = 1'b0;
    hold_flush     = 1'b0;
    parity_done    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (hdr_addr == ADDR_INVALID) begin
            state_next = DROP;
          end else begin
            addr_next   = hdr_addr;
            parity_next = data_in;
            err_next    = 1'b0;
            hold_load   = 1'b1;
`ifdef ROUTER_LEN_CHECK_EN
            len_next    = data_in[HDR_LEN_LSB +: LEN_W];
            cnt_next    = '0;
`endif
            state_next  = empty_sel[hdr_addr] ? PAYLOAD : WAIT_EMPTY;
          end
        end
      end
      WAIT_EMPTY: begin
        if (empty_sel[addr_reg]) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (accept) begin
          hold_load = 1'b1;
          if (pkt_valid) begin
            parity_next = parity_reg ^ data_in;
`ifdef ROUTER_LEN_CHECK_EN
            cnt_next    = sat_inc(cnt_reg);
`endif
          end else begin
            rx_parity_next = data_in;
            state_next     = PARITY_DRAIN;
          end
        end
      end
      PARITY_DRAIN: begin
        if (drain_ok) state_next = CHECK;
      end
      CHECK: begin
        parity_done = 1'b1;
`ifdef ROUTER_LEN_CHECK_EN
        err_next    = (rx_parity_reg != parity_reg) | (cnt_reg != len_reg);
`else
        err_next    = (rx_parity_reg != parity_reg);
`endif
        state_next  = IDLE;
      end
      DROP: begin
        // The parity byte (pkt_valid low) closes the discarded packet.
        if (!pkt_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A timeout flush of the active FIFO abandons the packet without judging it.
    if (abort) begin
      state_next  = IDLE;
      hold_load   = 1'b0;
      hold_flush  = 1'b1;
      err_next    = err_reg;
      parity_done = 1'b0;
    end
  end

endmodule
